cfeb_resync_align: RTL and testbench
====================================

// Module: cfeb_resync_align
// PURPOSE
//   Per-fiber frame-marker alignment after a TTC resync. For each CFEB optical link it hunts for the
//   FC frame separator, then checks the BC/FC cadence over several marker periods. Once locked it
//   raises cfeb_sync_done[i]. Sits between the CFEB GTX receivers and csc_sync_mon, which consumes
//   cfeb_sync_done. Also keeps a saturating per-link count of cadence errors seen after lock.
// PARAMETERS
//   MXCFEB        5    number of CFEB links
//   MARKER_PERIOD 128  clocks between FC separators (BC on every other clock); range 2..256
//   NLOCK         3    consecutive correctly placed FC markers needed to declare lock; range 1..15
// PORTS
//   clock              in   1   LHC 40 MHz clock; the only clock
//   global_reset_n     in   1   reset; asynchronous assert, active-low
//   ttc_resync         in   1   one-clock pulse; restarts alignment on all links
//   cfeb0..4_kchar     in   8   per-link K-character byte, one per clock
//   cfeb_fiber_enable  in   5   per-link enable
//   link_good          in   5   per-link receiver lock/good
//   cfeb_sync_done     out  5   per-link: aligned, or fiber disabled
//   cfeb_align_err     out  40  per-link 8-bit saturating error count; link i is bits [8i+7:8i]
// BEHAVIOUR
//   Reset (async, global_reset_n=0):
//     - every lane goes to IDLE; phase=0, hits=0
//     - cfeb_sync_done = 5'h00 is the raw register value during reset
//     - cfeb_align_err = 0
//   Disabled fiber: cfeb_fiber_enable[i]=0 forces cfeb_sync_done[i]=1 combinationally and holds the
//     lane in IDLE. This lets the &cfeb_sync_done term downstream ignore that link.
//   Lane state machine (all outputs registered):
//     - IDLE:   go to HUNT when enable & link_good.
//     - HUNT:   kchar==8'hFC -> VERIFY, phase<=1, hits<=1.
//               Any other kchar: stay in HUNT.
//     - VERIFY: expected kchar is FC when phase==0, otherwise BC.
//               Match: phase<=(phase==MARKER_PERIOD-1)?0:phase+1.
//               FC match with hits+1==NLOCK -> DONE; any other FC match: hits++.
//               Mismatch -> HUNT, hits<=0, and the error counter does not change.
//     - DONE:   cfeb_sync_done[i]=1; the phase keeps tracking.
//               Mismatch: err++ (saturates at 8'hFF), state stays DONE.
//   Latency: cfeb_sync_done rises on the clock after the NLOCK-th correct FC is sampled.
//   NLOCK=1: lock occurs on the first FC in HUNT. The next state is DONE directly, not VERIFY.
//   Phase wrap: the counter is 8 bits. MARKER_PERIOD=256 wraps naturally from 255 to 0.
//   Events, highest priority first:
//     - reset
//     - ~enable -> IDLE
//     - ~link_good -> IDLE, with sync_done low and err held
//     - ttc_resync -> HUNT, with sync_done low, err cleared, hits=0. The kchar on the resync cycle
//       is ignored.
//     - normal state-machine transitions
//   link_good returning: IDLE -> HUNT on the next clock.
//   A ttc_resync while a lane is in DONE drops sync_done on the following clock.
// STRUCTURE
//   - cfeb_sync_pkg (shared) holds:
//       localparams K_BC=8'hBC and K_FC=8'hFC
//       lane state encoding: IDLE=2'd0, HUNT=1, VERIFY=2, DONE=3
//   - Sub-module cfeb_resync_align_lane holds one lane: state machine, phase, hits and err registers.
//   - Top level:
//       packs the five kchar inputs into an array
//       generate-loops MXCFEB lanes
//       applies the disabled-fiber force
//       concatenates the err buses
// TESTING
//   1. Clean stream on all links, BC with FC every 128 clocks, then ttc_resync.
//      -> each sync_done rises 1 clk after the 3rd FC; err=0.
//   2. Link 2 carries a single 8'h50 between FC #1 and FC #2.
//      -> lane 2 returns to HUNT and locks 1 clk after FC #4; the other lanes are unaffected.
//   3. After lock, inject 300 bad kchars on link 0.
//      -> err[7:0] saturates at 8'hFF and sync_done[0] stays 1.
//      Then ttc_resync -> err=0 and sync_done[0]=0 on the next clock.
//   4. fiber_enable=5'b11011 with link 2 sending garbage.
//      -> sync_done[2]=1 throughout and err[23:16]=0.
//   5. Drop link_good[3] for 10 clk while locked.
//      -> sync_done[3]=0 the next clk; relock after 3 FCs once link_good returns; err held.
//   6. Assert global_reset_n low mid-VERIFY, asynchronously between edges.
//      -> outputs are immediately 0, except disabled lanes, which read 1.

Source files
------------

// File: rtl/cfeb_sync_pkg.sv
// Shared constants for CFEB frame-marker alignment: K-characters and lane state encoding.
package cfeb_sync_pkg;

   localparam logic [7:0] K_BC = 8'hBC;
   localparam logic [7:0] K_FC = 8'hFC;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StHunt   = 2'd1;
   localparam logic [1:0] StVerify = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/cfeb_resync_align_lane.sv
// One CFEB link: hunts for the FC separator, verifies the BC/FC cadence, then tracks it and
// counts cadence errors after lock.
module cfeb_resync_align_lane
   import cfeb_sync_pkg::*;
#(
   parameter int unsigned MarkerPeriod = 128,
   parameter int unsigned NLock        = 3
) (
   input  logic       clock,
   input  logic       global_reset_n,
   input  logic       resync_i,
   input  logic       enable_i,
   input  logic       link_good_i,
   input  logic [7:0] kchar_i,
   output logic       sync_done_o,
   output logic [7:0] err_o
);

   localparam logic [7:0] LastPhase = 8'(MarkerPeriod - 1);
   localparam logic [3:0] LockHits  = 4'(NLock);

   logic [1:0] state_q, state_d;
   logic [7:0] phase_q, phase_d;
   logic [3:0] hits_q, hits_d;
   logic [7:0] err_q, err_d;
   logic       done_q, done_d;

   logic [7:0] phase_next;
   logic [3:0] hits_inc;
   logic       match;
   logic       fc_match;

   // With MarkerPeriod=256 LastPhase is 255, so the wrap falls out of the 8-bit compare.
   assign phase_next = (phase_q == LastPhase) ? 8'd0 : phase_q + 8'd1;
   assign hits_inc   = hits_q + 4'd1;
   assign match      = (kchar_i == ((phase_q == 8'd0) ? K_FC : K_BC));
   assign fc_match   = match && (phase_q == 8'd0);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      hits_d  = hits_q;
      err_d   = err_q;
      if (!enable_i || !link_good_i) begin
         state_d = StIdle;
         phase_d = 8'd0;
         hits_d  = 4'd0;
      end else if (resync_i) begin
         state_d = StHunt;
         phase_d = 8'd0;
         hits_d  = 4'd0;
         err_d   = 8'd0;
      end else begin
         case (state_q)
            StIdle: state_d = StHunt;
            StHunt: begin
               if (kchar_i == K_FC) begin
                  phase_d = 8'd1;
                  hits_d  = 4'd1;
                  state_d = (LockHits == 4'd1) ? StDone : StVerify;
               end
            end
            StVerify: begin
               if (match) begin
                  phase_d = phase_next;
                  if (fc_match) begin
                     hits_d = hits_inc;
                     if (hits_inc == LockHits) state_d = StDone;
                  end
               end else begin
                  state_d = StHunt;
                  phase_d = 8'd0;
                  hits_d  = 4'd0;
               end
            end
            StDone: begin
               phase_d = phase_next;
               if (!match) err_d = sat_inc8(err_q);
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign done_d = (state_d == StDone);

   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state_q <= StIdle;
         phase_q <= 8'd0;
         hits_q  <= 4'd0;
         err_q   <= 8'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         hits_q  <= hits_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign sync_done_o = done_q;
   assign err_o       = err_q;

endmodule

// File: rtl/cfeb_resync_align.sv
// Per-fiber frame-marker alignment after a TTC resync for the CFEB optical links.
module cfeb_resync_align
   import cfeb_sync_pkg::*;
#(
   parameter int unsigned MXCFEB        = 5,
   parameter int unsigned MARKER_PERIOD = 128,
   parameter int unsigned NLOCK         = 3
) (
   input  logic                  clock,
   input  logic                  global_reset_n,
   input  logic                  ttc_resync,
   input  logic [7:0]            cfeb0_kchar,
   input  logic [7:0]            cfeb1_kchar,
   input  logic [7:0]            cfeb2_kchar,
   input  logic [7:0]            cfeb3_kchar,
   input  logic [7:0]            cfeb4_kchar,
   input  logic [MXCFEB-1:0]     cfeb_fiber_enable,
   input  logic [MXCFEB-1:0]     link_good,
   output logic [MXCFEB-1:0]     cfeb_sync_done,
   output logic [8*MXCFEB-1:0]   cfeb_align_err
);

   logic [7:0]        kchar [MXCFEB];
   logic [MXCFEB-1:0] done_raw;

   assign kchar[0] = cfeb0_kchar;
   assign kchar[1] = cfeb1_kchar;
   assign kchar[2] = cfeb2_kchar;
   assign kchar[3] = cfeb3_kchar;
   assign kchar[4] = cfeb4_kchar;

   for (genvar i = 0; i < MXCFEB; i++) begin : g_lane
      cfeb_resync_align_lane #(
         .MarkerPeriod (MARKER_PERIOD),
         .NLock        (NLOCK)
      ) u_lane (
         .clock          (clock),
         .global_reset_n (global_reset_n),
         .resync_i       (ttc_resync),
         .enable_i       (cfeb_fiber_enable[i]),
         .link_good_i    (link_good[i]),
         .kchar_i        (kchar[i]),
         .sync_done_o    (done_raw[i]),
         .err_o          (cfeb_align_err[8*i +: 8])
      );

      // A disabled fiber must not hold off the downstream &cfeb_sync_done, even in reset.
      assign cfeb_sync_done[i] = done_raw[i] | ~cfeb_fiber_enable[i];
   end

endmodule

// File: tb/tb_cfeb_resync_align.sv
// Directed, table-driven bench for cfeb_resync_align: each segment runs the marker stream up to
// an absolute tick with fixed controls, then compares sync_done and the error bus.
module tb_cfeb_resync_align;

   logic        clock = 1'b0;
   logic        global_reset_n;
   logic        ttc_resync;
   logic [7:0]  kchar [5];
   logic [4:0]  en;
   logic [4:0]  good;
   logic [4:0]  done;
   logic [39:0] err;

   int t       = 0;
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   cfeb_resync_align dut (
      .clock             (clock),
      .global_reset_n    (global_reset_n),
      .ttc_resync        (ttc_resync),
      .cfeb0_kchar       (kchar[0]),
      .cfeb1_kchar       (kchar[1]),
      .cfeb2_kchar       (kchar[2]),
      .cfeb3_kchar       (kchar[3]),
      .cfeb4_kchar       (kchar[4]),
      .cfeb_fiber_enable (en),
      .link_good         (good),
      .cfeb_sync_done    (done),
      .cfeb_align_err    (err)
   );

   typedef struct {
      string       name;
      int          t_end;
      logic        resync;
      logic [4:0]  en;
      logic [4:0]  good;
      logic [4:0]  bad;
      logic [7:0]  bad_val;
      logic [4:0]  exp_done;
      logic [39:0] exp_err;
   } seg_t;

   seg_t segs[$];

   task automatic add(input string name, input int t_end, input logic rs, input logic [4:0] e,
                      input logic [4:0] g, input logic [4:0] b, input logic [7:0] bv,
                      input logic [4:0] xd, input logic [39:0] xe);
      seg_t s;
      s.name = name; s.t_end = t_end; s.resync = rs; s.en = e; s.good = g;
      s.bad = b; s.bad_val = bv; s.exp_done = xd; s.exp_err = xe;
      segs.push_back(s);
   endtask

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Clean stream is FC on every 128th tick, BC otherwise; bad lanes carry bv instead.
   task automatic tick(input logic rs, input logic [4:0] bad, input logic [7:0] bv);
      for (int i = 0; i < 5; i++)
         kchar[i] = bad[i] ? bv : ((t % 128 == 0) ? 8'hFC : 8'hBC);
      ttc_resync = rs;
      @(posedge clock);
      #1;
      t++;
      ttc_resync = 1'b0;
   endtask

   localparam logic [39:0] E3 = 40'h00_05_00_00_00;

   initial begin
      logic first;
      global_reset_n = 1'b0;
      ttc_resync     = 1'b0;
      en             = 5'h1F;
      good           = 5'h1F;
      for (int i = 0; i < 5; i++) kchar[i] = 8'hBC;

      add("pre",         99,   0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h00, 40'h0);
      add("resync",      100,  1, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h00, 40'h0);
      add("verify1",     199,  0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h00, 40'h0);
      add("bad_l2",      200,  0, 5'h1F, 5'h1F, 5'h04, 8'h50, 5'h00, 40'h0);
      add("fc2",         383,  0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h00, 40'h0);
      add("fc3_lock",    384,  0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h1B, 40'h0);
      add("l2_pre",      511,  0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h1B, 40'h0);
      add("l2_lock",     512,  0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h1F, 40'h0);
      add("err_fe",      766,  0, 5'h1F, 5'h1F, 5'h01, 8'h00, 5'h1F, 40'hFE);
      add("err_sat",     812,  0, 5'h1F, 5'h1F, 5'h01, 8'h00, 5'h1F, 40'hFF);
      add("resync_clr",  813,  1, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h00, 40'h0);
      add("relock_pre",  1151, 0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h00, 40'h0);
      add("relock",      1152, 0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h1F, 40'h0);
      add("dis_first",   1153, 0, 5'h1B, 5'h1F, 5'h04, 8'h3C, 5'h1F, 40'h0);
      add("dis_run",     1300, 0, 5'h1B, 5'h1F, 5'h04, 8'h3C, 5'h1F, 40'h0);
      add("reen_pre",    1663, 0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h1B, 40'h0);
      add("reen_lock",   1664, 0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h1F, 40'h0);
      add("err_l3",      1669, 0, 5'h1F, 5'h1F, 5'h08, 8'h00, 5'h1F, E3);
      add("lg_drop1",    1670, 0, 5'h1F, 5'h17, 5'h00, 8'h00, 5'h17, E3);
      add("lg_drop10",   1679, 0, 5'h1F, 5'h17, 5'h00, 8'h00, 5'h17, E3);
      add("lg_pre",      2047, 0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h17, E3);
      add("lg_lock",     2048, 0, 5'h1F, 5'h1F, 5'h00, 8'h00, 5'h1F, E3);
      add("vmid_drop",   2049, 0, 5'h1B, 5'h17, 5'h00, 8'h00, 5'h17, E3);
      add("vmid",        2200, 0, 5'h1B, 5'h1F, 5'h00, 8'h00, 5'h17, E3);

      #12;
      check("rst_done", {35'd0, done}, 40'h0);
      check("rst_err", err, 40'h0);
      @(negedge clock);
      global_reset_n = 1'b1;

      foreach (segs[k]) begin
         en    = segs[k].en;
         good  = segs[k].good;
         first = 1'b1;
         while (t <= segs[k].t_end) begin
            tick(segs[k].resync && first, segs[k].bad, segs[k].bad_val);
            first = 1'b0;
         end
         check({segs[k].name, "_done"}, {35'd0, done}, {35'd0, segs[k].exp_done});
         check({segs[k].name, "_err"}, err, segs[k].exp_err);
      end

      // Lane 3 is mid-VERIFY with a held error count; reset lands between clock edges.
      #3;
      global_reset_n = 1'b0;
      #1;
      check("async_rst_done", {35'd0, done}, 40'h04);
      check("async_rst_err", err, 40'h0);
      @(negedge clock);
      global_reset_n = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b0, 5'h00, 8'h00);
      check("post_rst_done", {35'd0, done}, 40'h04);
      check("post_rst_err", err, 40'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
